// File: rtl/memx_ram_resp.sv
// Word-addressed RAM responder for the memx request/busy protocol.
// Each accepted request holds busy for a fixed latency, then commits the write or returns read data.
module memx_ram_resp #(
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter int unsigned RAM_N_OF_WORDS = 200,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RD_LATENCY     = 3,
    parameter int unsigned WR_LATENCY     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mem_rd_i,
    input  logic                      mem_wr_i,
    input  logic [RAM_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_wd_i,
    output logic                      busy_o,
    output logic [DATA_WIDTH-1:0]     mem_rd_o,
    output logic                      rvalid_o,
    output logic                      err_o
);

    localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    localparam logic [RAM_ADDR_WIDTH:0] NumWords = RAM_N_OF_WORDS[RAM_ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        StIdle,
        StRdBusy,
        StWrBusy
    } state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wd_q, wd_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;
    logic                      ram_we;
    logic                      addr_ok;

    logic [DATA_WIDTH-1:0] ram_q [RAM_N_OF_WORDS];

    assign addr_ok = ({1'b0, mem_addr_i} < NumWords);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        rd_data_d = rd_data_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_wr_i || mem_rd_i) begin
                    if (!addr_ok) begin
                        err_d = 1'b1;
                    end else if (mem_wr_i) begin
                        state_d = StWrBusy;
                        cnt_d   = CntW'(WR_LATENCY - 1);
                        addr_d  = mem_addr_i;
                        wd_d    = mem_wd_i;
                    end else begin
                        state_d = StRdBusy;
                        cnt_d   = CntW'(RD_LATENCY - 1);
                        addr_d  = mem_addr_i;
                    end
                end
            end
            StRdBusy: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    rd_data_d = ram_q[addr_q];
                    rvalid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ram_we  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            rd_data_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            rd_data_q <= rd_data_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Array is not reset; an aborted write never reaches here because reset forces StIdle.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram_q[addr_q] <= wd_q;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign mem_rd_o = rd_data_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_memx_ram_resp.sv
// Self-checking bench for memx_ram_resp: directed scenarios plus random traffic
// against an array model of the RAM.
module tb_memx_ram_resp;

    localparam int RdLat  = 3;
    localparam int WrLat  = 4;
    localparam int NWords = 200;

    logic        clk_i;
    logic        rst_ni;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [7:0]  mem_addr_i;
    logic [31:0] mem_wd_i;
    logic        busy_o;
    logic [31:0] mem_rd_o;
    logic        rvalid_o;
    logic        err_o;

    int n_checks;
    int n_fail;

    logic [31:0] ref_mem [256];
    bit          known   [256];

    memx_ram_resp dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .mem_addr_i (mem_addr_i),
        .mem_wd_i   (mem_wd_i),
        .busy_o     (busy_o),
        .mem_rd_o   (mem_rd_o),
        .rvalid_o   (rvalid_o),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Issues one request and measures the response; all comparisons are in the callers.
    task automatic do_op(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input bit perturb,
                         output int busy_n, output logic err_n1, output logic rv_fall,
                         output logic rv_next, output logic rv_early, output logic [31:0] rdata);
        @(negedge clk_i);
        mem_rd_i   = rd;
        mem_wr_i   = wr;
        mem_addr_i = a;
        mem_wd_i   = d;
        @(negedge clk_i);
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        err_n1   = err_o;
        busy_n   = 0;
        rv_early = 1'b0;
        while (busy_o && busy_n < 50) begin
            busy_n++;
            if (rvalid_o) rv_early = 1'b1;
            if (perturb) begin
                mem_rd_i   = 1'b1;
                mem_wr_i   = 1'($urandom_range(0, 1));
                mem_addr_i = 8'($urandom_range(0, NWords - 1));
                mem_wd_i   = $urandom;
            end
            @(negedge clk_i);
        end
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        rv_fall  = rvalid_o;
        rdata    = mem_rd_o;
        @(negedge clk_i);
        rv_next  = rvalid_o | err_o;
    endtask

    task automatic test_reset();
        // Start a read, then pull reset a few ns into the busy period.
        @(negedge clk_i);
        mem_rd_i   = 1'b1;
        mem_addr_i = 8'd5;
        @(posedge clk_i);
        #3;
        mem_rd_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got %b want 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || rvalid_o !== 1'b0 || err_o !== 1'b0 || mem_rd_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b rvalid=%b err=%b rd=%h want 0/0/0/0",
                     busy_o, rvalid_o, err_o, mem_rd_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (busy_o !== 1'b0 || rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet: cycle %0d got busy=%b rvalid=%b want 0/0",
                         i, busy_o, rvalid_o);
            end
        end
    endtask

    task automatic test_write_read();
        int b; logic e, rf, rn, re; logic [31:0] q;
        do_op(1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, b, e, rf, rn, re, q);
        ref_mem[5] = 32'hDEADBEEF; known[5] = 1'b1;
        n_checks++;
        if (b !== WrLat || rf !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_busy: got busy=%0d rvalid=%b err=%b want %0d/0/0", b, rf, e, WrLat);
        end
        do_op(1'b1, 1'b0, 8'd5, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (b !== RdLat) begin
            n_fail++;
            $display("FAIL rd_busy: got %0d want %0d", b, RdLat);
        end
        n_checks++;
        if (rf !== 1'b1 || re !== 1'b0 || rn !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_rvalid_pulse: got fall=%b early=%b next=%b want 1/0/0", rf, re, rn);
        end
        n_checks++;
        if (q !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data: got %h want deadbeef", q);
        end
    endtask

    task automatic test_priority();
        int b; logic e, rf, rn, re; logic [31:0] q;
        do_op(1'b1, 1'b1, 8'd7, 32'h1234, 1'b0, b, e, rf, rn, re, q);
        ref_mem[7] = 32'h1234; known[7] = 1'b1;
        n_checks++;
        if (b !== WrLat || rf !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_busy: got busy=%0d rvalid=%b want %0d/0", b, rf, WrLat);
        end
        do_op(1'b1, 1'b0, 8'd7, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (q !== 32'h1234 || rf !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_data: got %h rvalid=%b want 00001234/1", q, rf);
        end
    endtask

    task automatic test_invalid();
        int b; logic e, rf, rn, re; logic [31:0] q;
        do_op(1'b0, 1'b1, 8'(NWords), 32'hFFFF_FFFF, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (e !== 1'b1 || b !== 0 || rn !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_wr: got err=%b busy=%0d err_next=%b want 1/0/0", e, b, rn);
        end
        do_op(1'b1, 1'b0, 8'(NWords), 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (e !== 1'b1 || b !== 0 || rf !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_rd: got err=%b busy=%0d rvalid=%b want 1/0/0", e, b, rf);
        end
        do_op(1'b1, 1'b0, 8'd255, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (e !== 1'b1 || b !== 0) begin
            n_fail++;
            $display("FAIL inv_rd_255: got err=%b busy=%0d want 1/0", e, b);
        end
        do_op(1'b1, 1'b0, 8'd5, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (q !== ref_mem[5] || e !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_unchanged: got %h err=%b want %h/0", q, e, ref_mem[5]);
        end
    endtask

    task automatic test_ignore_busy();
        int b; logic e, rf, rn, re; logic [31:0] q;
        do_op(1'b0, 1'b1, 8'd3, 32'hCAFE_0003, 1'b1, b, e, rf, rn, re, q);
        ref_mem[3] = 32'hCAFE_0003; known[3] = 1'b1;
        n_checks++;
        if (b !== WrLat || rf !== 1'b0 || rn !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_busy: got busy=%0d rvalid=%b next=%b want %0d/0/0", b, rf, rn, WrLat);
        end
        do_op(1'b1, 1'b0, 8'd3, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (q !== 32'hCAFE_0003) begin
            n_fail++;
            $display("FAIL ign_data: got %h want cafe0003", q);
        end
    endtask

    task automatic test_reset_abort();
        int b; logic e, rf, rn, re; logic [31:0] q;
        do_op(1'b0, 1'b1, 8'd9, 32'hAA, 1'b0, b, e, rf, rn, re, q);
        ref_mem[9] = 32'hAA; known[9] = 1'b1;
        @(negedge clk_i);
        mem_wr_i   = 1'b1;
        mem_addr_i = 8'd9;
        mem_wd_i   = 32'h55;
        @(negedge clk_i);
        mem_wr_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: got %b want 1", busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b want 0", busy_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(1'b1, 1'b0, 8'd9, 32'h0, 1'b0, b, e, rf, rn, re, q);
        n_checks++;
        if (q !== 32'hAA || rf !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_data: got %h rvalid=%b want 000000aa/1", q, rf);
        end
    endtask

    task automatic test_random();
        int b; logic e, rf, rn, re; logic [31:0] q;
        int kind; logic [7:0] a; logic [31:0] d; logic rd, wr; bit valid;
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 2));
            a     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NWords, 255))
                                                : 8'($urandom_range(0, NWords - 1));
            d     = $urandom;
            valid = (int'(a) < NWords);
            if (kind == 0 && valid && !known[a]) kind = 1;
            rd = (kind == 0) || (kind == 2);
            wr = (kind == 1) || (kind == 2);
            do_op(rd, wr, a, d, 1'($urandom_range(0, 1)), b, e, rf, rn, re, q);
            n_checks++;
            if (!valid) begin
                if (e !== 1'b1 || b !== 0 || rf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_inv[%0d]: addr=%0d got err=%b busy=%0d rvalid=%b want 1/0/0",
                             i, a, e, b, rf);
                end
            end else if (wr) begin
                ref_mem[a] = d;
                known[a]   = 1'b1;
                if (e !== 1'b0 || b !== WrLat || rf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_wr[%0d]: addr=%0d got err=%b busy=%0d rvalid=%b want 0/%0d/0",
                             i, a, e, b, rf, WrLat);
                end
            end else begin
                if (e !== 1'b0 || b !== RdLat || rf !== 1'b1 || q !== ref_mem[a]) begin
                    n_fail++;
                    $display("FAIL rand_rd[%0d]: addr=%0d got err=%b busy=%0d rvalid=%b data=%h want 0/%0d/1/%h",
                             i, a, e, b, rf, q, RdLat, ref_mem[a]);
                end
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_ni     = 1'b0;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b0;
        mem_addr_i = '0;
        mem_wd_i   = '0;
        for (int i = 0; i < 256; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = '0;
        end
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || rvalid_o !== 1'b0 || err_o !== 1'b0 || mem_rd_o !== 32'h0) begin
            n_fail++;
            $display("FAIL init_reset: got busy=%b rvalid=%b err=%b rd=%h want 0/0/0/0",
                     busy_o, rvalid_o, err_o, mem_rd_o);
        end
        rst_ni = 1'b1;

        test_write_read();
        test_reset();
        test_priority();
        test_invalid();
        test_ignore_busy();
        test_reset_abort();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
